// File: rtl/padctl_gpio_cond_if.sv
// Pad-conditioning bus: the core-side and pad-side vectors of padctl_gpio_cond.
// The master drives the raw pads and core controls; the slave is the
// conditioning block itself.
interface padctl_gpio_cond_if #(
  parameter int NumPads = 32
);
  logic [NumPads-1:0] pad_in_i;
  logic [NumPads-1:0] filter_en_i;
  logic [NumPads-1:0] od_en_i;
  logic [NumPads-1:0] d2p_i;
  logic [NumPads-1:0] d2p_en_i;
  logic [NumPads-1:0] p2d_o;
  logic [NumPads-1:0] rise_o;
  logic [NumPads-1:0] fall_o;
  logic [NumPads-1:0] pad_out_o;
  logic [NumPads-1:0] pad_oe_o;

  modport master (
    output pad_in_i, filter_en_i, od_en_i, d2p_i, d2p_en_i,
    input  p2d_o, rise_o, fall_o, pad_out_o, pad_oe_o
  );

  modport slave (
    input  pad_in_i, filter_en_i, od_en_i, d2p_i, d2p_en_i,
    output p2d_o, rise_o, fall_o, pad_out_o, pad_oe_o
  );
endinterface

// File: rtl/padctl_gpio_cond.sv
// Per-channel GPIO pad conditioning: input synchroniser, optional
// counter-based glitch filter, rise/fall pulses, and a registered
// push-pull / open-drain output stage. All channels are independent.
module padctl_gpio_cond #(
  parameter int   NumPads      = 32,
  parameter int   SyncStages   = 2,
  parameter int   FilterCycles = 4,
  parameter logic ResetVal     = 1'b0
) (
  input logic            clk_i,
  input logic            rst_ni,
  padctl_gpio_cond_if.slave bus
);

  if (NumPads < 1) begin : g_bad_num_pads
    $fatal(1, "padctl_gpio_cond: NumPads must be >= 1");
  end
  if (SyncStages < 2) begin : g_bad_sync_stages
    $fatal(1, "padctl_gpio_cond: SyncStages must be >= 2");
  end
  if (FilterCycles < 1) begin : g_bad_filter_cycles
    $fatal(1, "padctl_gpio_cond: FilterCycles must be >= 1");
  end

  localparam int CntW = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);
  localparam logic [NumPads-1:0] ResetVec = {NumPads{ResetVal}};

  logic [NumPads-1:0] sync_r [SyncStages];
  logic [NumPads-1:0] sync_q;
  logic [CntW-1:0]    cnt_q  [NumPads];
  logic [NumPads-1:0] p2d_q;
  logic [NumPads-1:0] hist_q;
  logic [NumPads-1:0] pad_out_q;
  logic [NumPads-1:0] pad_oe_q;

  assign sync_q = sync_r[SyncStages-1];

  // Metastability synchroniser chain for the asynchronous pad levels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SyncStages; i++) begin
        sync_r[i] <= ResetVec;
      end
    end else begin
      sync_r[0] <= bus.pad_in_i;
      for (int unsigned i = 1; i < SyncStages; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Glitch filter and accepted-level register; with filtering off or
  // FilterCycles=1 (CntMax=0) a differing sync_q is accepted immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned ch = 0; ch < NumPads; ch++) begin
        cnt_q[ch] <= '0;
      end
      p2d_q  <= ResetVec;
      hist_q <= ResetVec;
    end else begin
      hist_q <= p2d_q;
      for (int unsigned ch = 0; ch < NumPads; ch++) begin
        if (sync_q[ch] == p2d_q[ch]) begin
          cnt_q[ch] <= '0;
        end else if (!bus.filter_en_i[ch] || (cnt_q[ch] == CntMax)) begin
          p2d_q[ch] <= sync_q[ch];
          cnt_q[ch] <= '0;
        end else begin
          cnt_q[ch] <= cnt_q[ch] + CntW'(1);
        end
      end
    end
  end

  // Output stage: open-drain only ever drives low and releases for a 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      pad_out_q <= bus.d2p_i & ~bus.od_en_i;
      pad_oe_q  <= bus.d2p_en_i & ~(bus.od_en_i & bus.d2p_i);
    end
  end

  assign bus.p2d_o     = p2d_q;
  assign bus.rise_o    = p2d_q & ~hist_q;
  assign bus.fall_o    = ~p2d_q & hist_q;
  assign bus.pad_out_o = pad_out_q;
  assign bus.pad_oe_o  = pad_oe_q;

endmodule

// File: tb/tb_padctl_gpio_cond.sv
// Directed bench for padctl_gpio_cond with NumPads=4, SyncStages=2,
// FilterCycles=4, ResetVal=0. Edge counts below include the edge on which
// stage 1 first samples the new pad level as edge 1.
module tb_padctl_gpio_cond;

  localparam int NP = 4;

  logic clk_i;
  logic rst_ni;
  int   n_assert;
  int   n_fail;

  padctl_gpio_cond_if #(.NumPads(NP)) bus ();

  padctl_gpio_cond #(
    .NumPads     (NP),
    .SyncStages  (2),
    .FilterCycles(4),
    .ResetVal    (1'b0)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_ni           = 1'b0;
    bus.pad_in_i     = '0;
    bus.filter_en_i  = '0;
    bus.od_en_i      = '0;
    bus.d2p_i        = '0;
    bus.d2p_en_i     = '0;

    // Reset state
    #2;
    chk("rst_p2d", bus.p2d_o, 4'b0000);
    chk("rst_rise", bus.rise_o, 4'b0000);
    chk("rst_fall", bus.fall_o, 4'b0000);
    chk("rst_pad_out", bus.pad_out_o, 4'b0000);
    chk("rst_pad_oe", bus.pad_oe_o, 4'b0000);
    tick();
    tick();
    #3 rst_ni = 1'b1;
    tick();
    chk("rel_p2d", bus.p2d_o, 4'b0000);
    chk("rel_rise", bus.rise_o, 4'b0000);
    chk("rel_fall", bus.fall_o, 4'b0000);

    // Unfiltered ch0 and filtered ch1 rising together
    bus.filter_en_i = 4'b0010;
    bus.pad_in_i    = 4'b0011;
    tick(); chk("lat_e1_p2d", bus.p2d_o, 4'b0000);
    tick(); chk("lat_e2_p2d", bus.p2d_o, 4'b0000);
    tick(); chk("lat_e3_p2d", bus.p2d_o, 4'b0001);
    chk("lat_e3_rise", bus.rise_o, 4'b0001);
    chk("lat_e3_fall", bus.fall_o, 4'b0000);
    tick(); chk("lat_e4_p2d", bus.p2d_o, 4'b0001);
    chk("lat_e4_rise", bus.rise_o, 4'b0000);
    tick(); chk("flt_e5_p2d", bus.p2d_o, 4'b0001);
    tick(); chk("flt_e6_p2d", bus.p2d_o, 4'b0011);
    chk("flt_e6_rise", bus.rise_o, 4'b0010);
    chk("flt_e6_fall", bus.fall_o, 4'b0000);
    tick(); chk("flt_e7_rise", bus.rise_o, 4'b0000);

    // Unfiltered fall on ch0
    bus.pad_in_i = 4'b0010;
    tick(); tick();
    chk("fall_e2_p2d", bus.p2d_o, 4'b0011);
    tick(); chk("fall_e3_p2d", bus.p2d_o, 4'b0010);
    chk("fall_e3_fall", bus.fall_o, 4'b0001);
    chk("fall_e3_rise", bus.rise_o, 4'b0000);
    tick(); chk("fall_e4_fall", bus.fall_o, 4'b0000);

    // Glitch rejection on ch2: repeated 3-high / 1-low bursts
    bus.filter_en_i = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      bus.pad_in_i = 4'b0110;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("glitch_hi_p2d", bus.p2d_o, 4'b0010);
        chk("glitch_hi_rise", bus.rise_o, 4'b0000);
      end
      bus.pad_in_i = 4'b0010;
      tick();
      chk("glitch_lo_p2d", bus.p2d_o, 4'b0010);
      chk("glitch_lo_fall", bus.fall_o, 4'b0000);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("glitch_tail_p2d", bus.p2d_o, 4'b0010);
      chk("glitch_tail_rise", bus.rise_o, 4'b0000);
    end

    // Output path: open-drain and push-pull
    bus.od_en_i  = 4'b1000;
    bus.d2p_en_i = 4'b1000;
    bus.d2p_i    = 4'b0000;
    tick();
    chk("od_low_oe", bus.pad_oe_o, 4'b1000);
    chk("od_low_out", bus.pad_out_o, 4'b0000);
    bus.d2p_i = 4'b1000;
    #2 chk("od_hold_oe", bus.pad_oe_o, 4'b1000);
    tick();
    chk("od_rel_oe", bus.pad_oe_o, 4'b0000);
    chk("od_rel_out", bus.pad_out_o, 4'b0000);
    bus.od_en_i = 4'b0000;
    bus.d2p_i   = 4'b1001;
    tick();
    chk("pp_out", bus.pad_out_o, 4'b1001);
    chk("pp_oe", bus.pad_oe_o, 4'b1000);
    bus.od_en_i = 4'b1000;
    tick();
    chk("sw_od_out", bus.pad_out_o, 4'b0001);
    chk("sw_od_oe", bus.pad_oe_o, 4'b0000);

    // Mid-count filter disable on ch1
    bus.filter_en_i = 4'b0000;
    bus.pad_in_i    = 4'b0000;
    tick(); tick(); tick(); tick();
    chk("mid_prep_p2d", bus.p2d_o, 4'b0000);
    bus.filter_en_i = 4'b0010;
    bus.pad_in_i    = 4'b0010;
    tick(); chk("mid_e1_p2d", bus.p2d_o, 4'b0000);
    tick(); tick(); tick();
    chk("mid_e4_p2d", bus.p2d_o, 4'b0000);
    bus.filter_en_i = 4'b0000;
    tick();
    chk("mid_e5_p2d", bus.p2d_o, 4'b0010);
    chk("mid_e5_rise", bus.rise_o, 4'b0010);

    // Async reset while ch1 filter count is 2
    bus.od_en_i  = 4'b0000;
    bus.d2p_i    = 4'b0001;
    bus.d2p_en_i = 4'b0001;
    bus.pad_in_i = 4'b0000;
    tick(); tick(); tick(); tick();
    chk("ar_prep_p2d", bus.p2d_o, 4'b0000);
    chk("ar_prep_out", bus.pad_out_o, 4'b0001);
    chk("ar_prep_oe", bus.pad_oe_o, 4'b0001);
    bus.filter_en_i = 4'b0010;
    bus.pad_in_i    = 4'b0011;
    tick(); tick(); tick();
    chk("ar_e3_p2d", bus.p2d_o, 4'b0001);
    tick();
    chk("ar_e4_p2d", bus.p2d_o, 4'b0001);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_async_p2d", bus.p2d_o, 4'b0000);
    chk("ar_async_rise", bus.rise_o, 4'b0000);
    chk("ar_async_fall", bus.fall_o, 4'b0000);
    chk("ar_async_out", bus.pad_out_o, 4'b0000);
    chk("ar_async_oe", bus.pad_oe_o, 4'b0000);
    #1 rst_ni = 1'b1;
    tick();
    chk("ar_r1_out", bus.pad_out_o, 4'b0001);
    chk("ar_r1_oe", bus.pad_oe_o, 4'b0001);
    chk("ar_r1_p2d", bus.p2d_o, 4'b0000);
    tick(); chk("ar_r2_p2d", bus.p2d_o, 4'b0000);
    tick(); chk("ar_r3_p2d", bus.p2d_o, 4'b0001);
    chk("ar_r3_rise", bus.rise_o, 4'b0001);
    tick(); tick();
    chk("ar_r5_p2d", bus.p2d_o, 4'b0001);
    tick();
    chk("ar_r6_p2d", bus.p2d_o, 4'b0011);
    chk("ar_r6_rise", bus.rise_o, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
